// File: rtl/mux_arbiter.sv
// Two-requester packet arbiter with round-robin tie break and beat limit.
// Define MUX_ARBITER_ASSERT_EN to compile in the runtime sanity assertions.
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_a,
  input  logic             last_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_A,
    GNT_B
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BEATS);

  state_t     state;
  logic       ptr_b;
  logic [3:0] beat_cnt;
  logic       xfer;
  logic       at_max;
  logic       grant_end;
  logic       own_req;
  logic       other_req;
  logic       win_a;
  logic       win_b;

  assign gnt_a     = (state == GNT_A);
  assign gnt_b     = (state == GNT_B);
  assign sel       = gnt_b;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign out_data  = sel ? data_b : data_a;
  assign out_last  = sel ? last_b : last_a;

  assign xfer      = out_valid & out_ready;
  assign at_max    = (beat_cnt + 4'd1) == MAX_CNT;
  assign grant_end = xfer & (out_last | at_max);
  assign own_req   = sel ? req_b : req_a;
  assign other_req = sel ? req_a : req_b;

  // ptr_b=1 means B was served last, so A wins a tie
  assign win_a = req_a & (~req_b | ptr_b);
  assign win_b = req_b & (~req_a | ~ptr_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr_b    <= 1'b1;
      beat_cnt <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            win_a: begin
              state    <= GNT_A;
              ptr_b    <= 1'b0;
              beat_cnt <= 4'd0;
            end
            win_b: begin
              state    <= GNT_B;
              ptr_b    <= 1'b1;
              beat_cnt <= 4'd0;
            end
            default: ;
          endcase
        end
        GNT_A, GNT_B: begin
          if (grant_end) begin
            beat_cnt <= 4'd0;
            if (other_req) begin
              state <= sel ? GNT_A : GNT_B;
              ptr_b <= ~sel;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 4'd1;
          end else if (!own_req) begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_ARBITER_ASSERT_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({req_a, req_b, sel, out_ready}))
        else $error("mux_arbiter: X/Z on control input");
      assert (!(gnt_a && gnt_b))
        else $fatal(1, "mux_arbiter: both grants high");
      assert (!(state == IDLE && out_valid))
        else $error("mux_arbiter: out_valid while idle");
    end
  end
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: packet-level reference model plus directed cases.
module tb_mux_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_a, req_b;
  logic [W-1:0] data_a, data_b;
  logic         last_a, last_b;
  logic         gnt_a, gnt_b, sel;
  logic         out_valid, out_last;
  logic [W-1:0] out_data;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .last_a    (last_a),
    .last_b    (last_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0=none 1=A 2=B, last_srv is who was served last,
  // beats counts transfers accepted in the current grant.
  int  owner    = 0;
  int  last_srv = 2;
  int  beats    = 0;
  bit  m_live   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      owner = 0; last_srv = 2; beats = 0; m_live = 1;
    end else if (m_live) begin
      if (owner == 0) begin
        if (req_a && req_b) owner = (last_srv == 1) ? 2 : 1;
        else if (req_a)     owner = 1;
        else if (req_b)     owner = 2;
        if (owner != 0) begin last_srv = owner; beats = 0; end
      end else begin
        bit mine, lst, other;
        mine  = (owner == 1) ? req_a  : req_b;
        lst   = (owner == 1) ? last_a : last_b;
        other = (owner == 1) ? req_b  : req_a;
        if (mine && out_ready) begin
          beats++;
          if (lst || beats == MB) begin
            beats = 0;
            if (other) begin
              owner    = 3 - owner;
              last_srv = owner;
            end else begin
              owner = 0;
            end
          end
        end else if (!mine) begin
          owner = 0; beats = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic ev;
      ev = (owner == 1 && req_a) || (owner == 2 && req_b);
      check("m_gnt_a", gnt_a, owner == 1);
      check("m_gnt_b", gnt_b, owner == 2);
      check("m_sel", sel, owner == 2);
      check("m_valid", out_valid, ev);
      check("m_data", out_data, (owner == 2) ? data_b : data_a);
      check("m_last", out_last, (owner == 2) ? last_b : last_a);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
    data_a = 8'h00; data_b = 8'h00;
    last_a = 1'b0; last_b = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_gnt_a", gnt_a, 1'b0);
    check("rst_gnt_b", gnt_b, 1'b0);
    check("rst_sel", sel, 1'b0);
    check("rst_valid", out_valid, 1'b0);

    // single one-beat A packet, then bubble re-grant, then drop
    req_b = 1'b0; data_a = 8'h11; last_a = 1'b1; rst_n = 1'b1;
    tick();
    check("t1_gnt_a", gnt_a, 1'b1);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 8'h11);
    tick();
    check("t1_idle", gnt_a, 1'b0);
    check("t1_idle_v", out_valid, 1'b0);
    tick();
    check("t1_regrant", gnt_a, 1'b1);
    req_a = 1'b0;
    tick();
    check("t1_drop", gnt_a, 1'b0);

    // tie with one-beat packets alternates A,B,A,B
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b1; last_b = 1'b1;
    data_a = 8'hAA; data_b = 8'hBB;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_gnt_a", gnt_a, (i % 2) == 0);
      check("t2_gnt_b", gnt_b, (i % 2) == 1);
      check("t2_data", out_data, (i % 2) ? 8'hBB : 8'hAA);
    end

    // long A packet cut at MAX_BEATS, then B
    last_a = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < MB; i++) begin
      check("t3_gnt_a", gnt_a, 1'b1);
      check("t3_valid", out_valid, 1'b1);
      tick();
    end
    check("t3_gnt_b", gnt_b, 1'b1);

    // backpressure holds grant and count
    req_b = 1'b0; out_ready = 1'b0; data_a = 8'h5A;
    do_reset();
    tick();
    repeat (5) begin
      check("t4_hold_gnt", gnt_a, 1'b1);
      check("t4_hold_data", out_data, 8'h5A);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < MB; i++) begin
      check("t4_beat_gnt", gnt_a, 1'b1);
      tick();
    end
    check("t4_release", gnt_a, 1'b0);
    req_a = 1'b0;

    // reset during beat 2 of a B packet
    req_b = 1'b1; last_b = 1'b0; data_b = 8'h3C;
    do_reset();
    tick();
    tick();
    check("t5_gnt_b", gnt_b, 1'b1);
    check("t5_sel", sel, 1'b1);
    rst_n = 1'b0;
    tick();
    check("t5_rst_gnt_b", gnt_b, 1'b0);
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_sel", sel, 1'b0);
    rst_n = 1'b1; req_a = 1'b1;
    tick();
    check("t5_tie_a", gnt_a, 1'b1);

    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
